// File: rtl/bus_pkg.sv
// Shared types for the register-bus arbiter.
//   BUS_ADDR_W / BUS_DATA_W : default bus widths
//   bus_req_t               : one buffered request {addr, wdata, rw}
//   arb_state_t             : arbiter FSM states
package bus_pkg;
  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 16;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] wdata;
    logic                  rw;
  } bus_req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;
endpackage

// File: rtl/bus_arbiter_req_slot.sv
// One-deep holding register for a single requester.
//   clk, rst  : clock, synchronous active-high reset
//   valid/req : one-cycle request strobe and its payload
//   clr       : arbiter is retiring the held request this cycle
//   full/held : slot occupancy and held payload
//   overflow  : one-cycle pulse, a request arrived while the slot was busy
module req_slot
  import bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     valid,
  input  bus_req_t req,
  input  logic     clr,
  output logic     full,
  output bus_req_t held,
  output logic     overflow
);

  // A slot being retired this cycle can accept the next request directly.
  logic load;
  assign load = valid && (!full || clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      held     <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= valid && full && !clr;
      if (load) begin
        held <= req;
        full <= 1'b1;
      end else if (clr) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter for the register bus. Each requester's
// pulse is buffered in a one-deep slot; one transaction at a time is issued
// into the core chain and the chain's return (or a timeout) is routed back
// to the owner.
//   clk, rst                            : clock, synchronous active-high reset
//   addr/wdata/rw/valid{0,1}_i          : request from requester n
//   rdata/rw/valid{0,1}_o               : response to requester n
//   overflow{0,1}_o                     : request dropped, slot full
//   addr_o/wdata_o/rw_o/valid_o         : request into the chain
//   rdata_i/rw_i/valid_i                : response from the end of the chain
//   timeout_o                           : transaction aborted, no response
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int ADDR_W  = BUS_ADDR_W,
  parameter int DATA_W  = BUS_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic              rw0_i,
  input  logic              valid0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  input  logic              rw1_i,
  input  logic              valid1_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic              rw0_o,
  output logic              valid0_o,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              rw1_o,
  output logic              valid1_o,
  output logic              overflow0_o,
  output logic              overflow1_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic              rw_o,
  output logic              valid_o,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic              rw_i,
  input  logic              valid_i,
  output logic              timeout_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  arb_state_t    state_q, state_d;
  logic          gnt_q;     // owner of the outstanding transaction
  logic          rr_q;      // requester favoured when both slots are full
  logic [CW-1:0] cnt_q;

  bus_req_t req0, req1, held0, held1, gnt_req, own_req;
  logic     full0, full1, clr0, clr1;
  logic     issue_go, gnt_sel, rsp_ok, tmo, done;

  assign req0 = '{addr: addr0_i, wdata: wdata0_i, rw: rw0_i};
  assign req1 = '{addr: addr1_i, wdata: wdata1_i, rw: rw1_i};

  req_slot u_slot0 (.clk(clk), .rst(rst), .valid(valid0_i), .req(req0), .clr(clr0),
                    .full(full0), .held(held0), .overflow(overflow0_o));
  req_slot u_slot1 (.clk(clk), .rst(rst), .valid(valid1_i), .req(req1), .clr(clr1),
                    .full(full1), .held(held1), .overflow(overflow1_o));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (full0 || full1) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (valid_i || cnt_q == CNT_MAX) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM control outputs
  always_comb begin
    issue_go = (state_q == IDLE) && (full0 || full1);
    gnt_sel  = (full0 && full1) ? rr_q : full1;
    rsp_ok   = (state_q == WAIT) && valid_i;
    tmo      = (state_q == WAIT) && !valid_i && (cnt_q == CNT_MAX);
    done     = rsp_ok || tmo;
    clr0     = done && !gnt_q;
    clr1     = done && gnt_q;
  end

  assign gnt_req = gnt_sel ? held1 : held0;
  assign own_req = gnt_q ? held1 : held0;

  // Grant bookkeeping and timeout counter; the counter only runs in WAIT,
  // so it cannot wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_q <= 1'b0;
      rr_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      if (issue_go) gnt_q <= gnt_sel;
      if (done)     rr_q  <= ~gnt_q;
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
    end
  end

  // Registered bus and response outputs; fields are zero when not strobed.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_o   <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
      rw_o      <= 1'b0;
      valid0_o  <= 1'b0;
      rdata0_o  <= '0;
      rw0_o     <= 1'b0;
      valid1_o  <= 1'b0;
      rdata1_o  <= '0;
      rw1_o     <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      valid_o   <= issue_go;
      addr_o    <= issue_go ? gnt_req.addr  : '0;
      wdata_o   <= issue_go ? gnt_req.wdata : '0;
      rw_o      <= issue_go ? gnt_req.rw    : 1'b0;
      valid0_o  <= clr0;
      rdata0_o  <= (rsp_ok && !gnt_q) ? rdata_i : '0;
      rw0_o     <= clr0 ? (rsp_ok ? rw_i : own_req.rw) : 1'b0;
      valid1_o  <= clr1;
      rdata1_o  <= (rsp_ok && gnt_q) ? rdata_i : '0;
      rw1_o     <= clr1 ? (rsp_ok ? rw_i : own_req.rw) : 1'b0;
      timeout_o <= tmo;
    end
  end

endmodule
